// File: rtl/systolic_skew_feeder.sv
// West-edge feeder for the systolic array: accepts row-vector beats over
// valid/ready, delays lane i by i extra cycles (diagonal skew) with a matching
// acc_en, frames a tile of up to MAX_K beats, flushes, then pulses tile_done_o.
module systolic_skew_feeder #(
  parameter int N_LANES     = 4,
  parameter int INPUT_WIDTH = 9,
  parameter int MAX_K       = 256
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_LANES*INPUT_WIDTH-1:0] in_data,
  input  logic                           in_last,
  output logic [N_LANES*INPUT_WIDTH-1:0] lane_data_o,
  output logic [N_LANES-1:0]             lane_acc_en_o,
  output logic [$clog2(MAX_K+1)-1:0]     k_cnt_o,
  output logic                           busy_o,
  output logic                           tile_done_o
);

  localparam int KW = $clog2(MAX_K + 1);
  localparam int FW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state;
  logic [FW-1:0]   flush_cnt;
  logic [KW-1:0]   k_cnt;
  logic            tile_done;
  logic            accept;
  logic            beat_last;

  assign in_ready    = (state == S_IDLE) || (state == S_STREAM);
  assign accept      = in_valid && in_ready;
  assign busy_o      = (state != S_IDLE);
  assign k_cnt_o     = k_cnt;
  assign tile_done_o = tile_done;

  // Decide whether the beat offered now closes the tile (explicit or MAX_K limit)
  always_comb begin
    beat_last = in_last;
    if (state == S_IDLE) begin
      if (MAX_K == 1) beat_last = 1'b1;
    end else if (k_cnt == KW'(MAX_K - 1)) begin
      beat_last = 1'b1;
    end
  end

  // Tile framing FSM: stream beats, flush the skew pipe, pulse done
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
      k_cnt     <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            k_cnt     <= KW'(1);
            flush_cnt <= FW'(N_LANES - 1);
            state     <= beat_last ? S_FLUSH : S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            k_cnt <= k_cnt + KW'(1);
            if (beat_last) begin
              flush_cnt <= FW'(N_LANES - 1);
              state     <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FW'(1);
          end else begin
            state     <= S_DONE;
            tile_done <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-lane skew chains: lane i is (i+1) registers deep, last stage drives the array
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [INPUT_WIDTH-1:0] sd [0:i];
    logic                   sv [0:i];

    // Shift accepted beat (or a zero bubble) down this lane's chain
    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int unsigned j = 0; j < i + 1; j++) begin
          sd[j] <= '0;
          sv[j] <= 1'b0;
        end
      end else begin
        sd[0] <= accept ? in_data[i*INPUT_WIDTH +: INPUT_WIDTH] : '0;
        sv[0] <= accept;
        for (int unsigned j = 1; j < i + 1; j++) begin
          sd[j] <= sd[j-1];
          sv[j] <= sv[j-1];
        end
      end
    end

    assign lane_data_o[i*INPUT_WIDTH +: INPUT_WIDTH] = sd[i];
    assign lane_acc_en_o[i]                          = sv[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: a scoreboard of per-lane expected
// beats (with due cycle) plus a small tile model for ready/busy/done/k_cnt.
module tb_systolic_skew_feeder;

  localparam int N = 4;
  localparam int W = 9;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*W-1:0]  in_data = '0;
  logic            in_last = 1'b0;
  logic [N*W-1:0]  lane_data_o;
  logic [N-1:0]    lane_acc_en_o;
  logic [8:0]      k_cnt_o;
  logic            busy_o;
  logic            tile_done_o;

  logic            in_valid2 = 1'b0;
  logic            in_ready2;
  logic [N*W-1:0]  in_data2 = '0;
  logic [N*W-1:0]  lane_data2;
  logic [N-1:0]    lane_acc_en2;
  logic [1:0]      k_cnt2;
  logic            busy2;
  logic            tile_done2;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N_LANES(N), .INPUT_WIDTH(W), .MAX_K(256)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .lane_data_o(lane_data_o),
    .lane_acc_en_o(lane_acc_en_o), .k_cnt_o(k_cnt_o), .busy_o(busy_o),
    .tile_done_o(tile_done_o)
  );

  systolic_skew_feeder #(.N_LANES(N), .INPUT_WIDTH(W), .MAX_K(3)) dut_k3 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_last(1'b0), .lane_data_o(lane_data2),
    .lane_acc_en_o(lane_acc_en2), .k_cnt_o(k_cnt2), .busy_o(busy2),
    .tile_done_o(tile_done2)
  );

  typedef struct {
    int         due;
    int         lane;
    logic [8:0] data;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n = 0;
  int   done_due = 0;
  int   block_from = 1;
  int   exp_k = 0;
  bit   tile_open = 0;

  function automatic logic [N*W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic bit blocked();
    return (n >= block_from) && (n <= done_due);
  endfunction

  task automatic check_main();
    logic [9:0] exp;
    logic [9:0] obs;
    for (int i = 0; i < N; i++) begin
      exp = '0;
      for (int k = 0; k < q.size(); k++) begin
        if (q[k].due == n && q[k].lane == i) begin
          exp = {1'b1, q[k].data};
          q.delete(k);
          break;
        end
      end
      obs = {lane_acc_en_o[i], lane_data_o[i*W +: W]};
      chk($sformatf("lane%0d", i), 64'(obs), 64'(exp));
    end
    chk("in_ready", 64'(in_ready), 64'(!blocked()));
    chk("busy", 64'(busy_o), 64'(tile_open || blocked()));
    chk("tile_done", 64'(tile_done_o), 64'(n == done_due));
    chk("k_cnt", 64'(k_cnt_o), 64'(exp_k));
  endtask

  // Drive one cycle on the main DUT at a negedge, predict, then check next negedge
  task automatic tick(input logic v, input logic [N*W-1:0] d, input logic l);
    bit last;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    if (v && !blocked()) begin
      for (int i = 0; i < N; i++)
        q.push_back('{due: n + 1 + i, lane: i, data: d[i*W +: W]});
      if (!tile_open) exp_k = 1;
      else exp_k++;
      tile_open = 1;
      last = l || (exp_k == 256);
      if (last) begin
        tile_open  = 0;
        block_from = n + 1;
        done_due   = n + 1 + N;
      end
    end
    @(negedge clk);
    n++;
    check_main();
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) tick(1'b0, '0, 1'b0);
  endtask

  task automatic rst(input int cycles, input logic v);
    rstn     = 1'b0;
    in_valid = v;
    in_last  = 1'b0;
    in_data  = pack(5, 6, 7, 8);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n++;
    end
    q.delete();
    tile_open  = 0;
    done_due   = 0;
    block_from = 1;
    exp_k      = 0;
    check_main();
    rstn     = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    n++;

    // Reset held two cycles with valid asserted
    rst(2, 1'b1);
    idle(2);

    // Single-beat tile shows the diagonal skew and done timing
    tick(1'b1, pack(3, 1, -2, -2), 1'b1);
    idle(7);

    // Four back-to-back beats, last on the fourth
    tick(1'b1, pack(1, 10, 20, 30), 1'b0);
    tick(1'b1, pack(2, 11, 21, 31), 1'b0);
    tick(1'b1, pack(-3, 12, -22, 32), 1'b0);
    tick(1'b1, pack(1, 13, 23, -33), 1'b1);
    // Next beat held valid through flush; taken the cycle after DONE
    for (int c = 0; c < 6; c++) tick(1'b1, pack(-100, 100, -255, 255), 1'b1);
    idle(7);

    // Bubbles between beats must keep the same gap on every lane
    tick(1'b1, pack(7, 8, 9, 10), 1'b0);
    idle(2);
    tick(1'b1, pack(-7, -8, -9, -10), 1'b0);
    idle(1);
    tick(1'b1, pack(4, 5, 6, 127), 1'b1);
    idle(8);

    // Reset during FLUSH: in-flight data discarded, no done pulse
    tick(1'b1, pack(50, 51, 52, 53), 1'b1);
    idle(2);
    rst(1, 1'b0);
    idle(6);

    // MAX_K=3 instance: five beats offered without in_last, only three taken
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("k3_ready%0d", j), 64'(in_ready2), 64'((j < 3) || (j == 8)));
      chk($sformatf("k3_done%0d", j), 64'(tile_done2), 64'(j == 7));
      if (j == 6) chk("k3_lane3", 64'({lane_acc_en2[3], lane_data2[3*W +: W]}), 64'({1'b1, 9'd12}));
      if (j == 8) chk("k3_kcnt", 64'(k_cnt2), 64'(3));
      in_valid2 = (j < 5);
      in_data2  = pack(j < 2 ? j : 2, 0, 0, 10 + (j < 2 ? j : 2));
      tick(1'b0, '0, 1'b0);
    end
    chk("k3_busy_end", 64'(busy2), 64'(0));

    chk("scoreboard_drain", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
